ovi_wb_ram_slave: RTL and testbench
===================================

# ovi_wb_ram_slave

Wishbone B4 slave (responder) wrapping a single-port synchronous RAM, the target-side counterpart to the team's Wishbone master agents and interface. It answers classic single cycles and registered-feedback incrementing bursts (CTI/BTE), raising ERR for out-of-range addresses. It sits behind an interconnect slot or directly on an `ovi_wishbone` instance as the reference memory for bus-level verification.

## Interface
- WB_ADDR_W, 32, byte address width
- WB_DATA_W, 32, data width; must be 8, 16, 32 or 64
- MEM_AW, 10, log2 of RAM depth in words
- wb_clk  in  1  bus clock; all logic on rising edge
- wb_resetn  in  1  asynchronous, active-low reset
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  WB_ADDR_W  byte address
- wb_sel_i  in  WB_DATA_W/8  byte enables
- wb_dat_i  in  WB_DATA_W  write data
- wb_cti_i  in  3  cycle type: 000 classic, 001 const burst, 010 incr burst, 111 end of burst
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  out  WB_DATA_W  read data, valid while ack high
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- wb_rty_o  out  1  retry; constant 0

## Operation
- LSB = log2(WB_DATA_W/8); word index = adr[MEM_AW+LSB-1:LSB]; an address is out of range if any bit of adr[WB_ADDR_W-1:MEM_AW+LSB] is 1.
- A beat completes at a rising edge where cyc, stb and (ack or err) are all 1; writes commit and the burst address advances only at that edge.
- Writes update only the bytes whose sel bit is 1. Out-of-range beats get err instead of ack, write nothing and drive dat_o = 0.
- FSM states: IDLE, CLASSIC, BURST.
- IDLE: on cyc&stb, load the address register from adr, register dat_o/ack/err for that address, then go to BURST if cti is 001 or 010, otherwise to CLASSIC.
- CLASSIC: ack/err high for exactly one cycle, then drop and return to IDLE. A still-asserted stb starts a new access from IDLE.
- BURST: after each completed beat, the next address = current +1 (cti 010, wrapped per bte on the low 2/3/4 index bits; linear never wraps) or current (cti 001). Data and ack/err for the next address are registered at the same edge, giving one beat per cycle.
- BURST, cti 111 on a completed beat: that beat is the last one; ack drops and the FSM returns to IDLE.
- BURST, master wait state (stb=0 with cyc=1): ack/err drop the next cycle, the address holds, and the FSM stays in BURST. When stb rises again, ack/err return the following cycle.
- cyc=0 in any state: IDLE next edge, ack/err = 0. A burst that ends without cti 111 is abandoned with no side effects.
- Reset (asynchronous, any time, including mid-burst): FSM to IDLE; wb_dat_o, wb_ack_o, wb_err_o and wb_rty_o go to 0. RAM contents are not reset.
- wb_ack_o and wb_err_o are never both 1.

## Timing
- Classic: request first sampled at edge E0; ack/err high after E0; beat completes at E1; ack/err low after E1. This is one wait state, two cycles per access.
- Burst of N beats: first ack after E0, then beats complete on N consecutive edges if stb stays high. Total N+1 cycles.
- Read data is registered: dat_o changes only on edges that assert ack.

## Configuration
- OVI_WB_BURST_EN defined: CTI/BTE handling, the BURST state and the burst address generator are built.
- OVI_WB_BURST_EN undefined: wb_cti_i and wb_bte_i are ignored and every access is classic, one wait state each.

## Structure
- Package `ovi_wb_pkg` holds:
  - cti_e (CLASSIC, CONST, INCR, EOB)
  - bte_e (LINEAR, WRAP4, WRAP8, WRAP16)
  - the FSM state typedef
  - a function computing LSB from the data width
- Sub-module `ovi_wb_burst_addr`: combinational next-word-index computation from the current index, cti and bte. Compiled only under OVI_WB_BURST_EN.

## Test plan
- Classic write 0xDEADBEEF to 0x10 with sel=1111, then classic read of 0x10 -> ack one cycle after stb on each access, read returns 0xDEADBEEF.
- Write sel=0010 with data 0x0000AA00 over 0x11223344 at 0x20 -> read returns 0x1122AA44.
- Incr wrap4 read burst starting at word 6, 4 beats, last beat cti=111 -> words 6, 7, 4, 5 on consecutive cycles, ack drops after the 4th beat.
- Read of an address with bit MEM_AW+LSB set (0x1000 with the defaults) -> err=1 for one cycle, ack=0, dat_o=0, RAM unchanged.
- Linear burst with stb low for 2 cycles mid-burst -> ack low during the gap, burst resumes at the held address, no beat is skipped or repeated.
- wb_resetn low during the 3rd beat of a burst -> ack, err and dat_o are 0 immediately; after release, a classic read of word 0 completes normally.

Source files
------------

// File: rtl/ovi_wb_pkg.sv
// ovi_wb_pkg: shared Wishbone B4 cycle/burst encodings, slave FSM states and
// the data-width to byte-offset helper used by ovi_wb_ram_slave.
package ovi_wb_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIC,
        S_BURST
    } wb_state_e;

    // Number of byte-offset address bits below the word index
    function automatic int unsigned wb_lsb(input int unsigned dw);
        case (dw)
            8:       return 0;
            16:      return 1;
            64:      return 3;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/ovi_wb_burst_addr.sv
// ovi_wb_burst_addr: next word index for a registered-feedback burst.
// Built only when OVI_WB_BURST_EN is defined.
`ifdef OVI_WB_BURST_EN
module ovi_wb_burst_addr
    import ovi_wb_pkg::*;
#(
    parameter int unsigned AW = 30
) (
    input  logic [AW-1:0] i_cur,
    input  cti_e          i_cti,
    input  bte_e          i_bte,
    output logic [AW-1:0] o_next
);

    logic [AW-1:0] w_inc;

    assign w_inc = i_cur + AW'(1);

    // Constant bursts hold the index; incrementing bursts wrap on the low bits
    always_comb begin
        o_next = i_cur;
        if (i_cti == CTI_INCR) begin
            unique case (i_bte)
                BTE_LINEAR: o_next = w_inc;
                BTE_WRAP4:  o_next = {i_cur[AW-1:2], w_inc[1:0]};
                BTE_WRAP8:  o_next = {i_cur[AW-1:3], w_inc[2:0]};
                BTE_WRAP16: o_next = {i_cur[AW-1:4], w_inc[3:0]};
                default:    o_next = w_inc;
            endcase
        end
    end

endmodule
`endif

// File: rtl/ovi_wb_ram_slave.sv
// ovi_wb_ram_slave: Wishbone B4 slave in front of a single-port synchronous
// RAM. Classic cycles take one wait state; out-of-range addresses get ERR.
// Define OVI_WB_BURST_EN to add CTI/BTE registered-feedback bursts.
module ovi_wb_ram_slave
    import ovi_wb_pkg::*;
#(
    parameter int unsigned WB_ADDR_W = 32,
    parameter int unsigned WB_DATA_W = 32,
    parameter int unsigned MEM_AW    = 10
) (
    input  logic                   wb_clk,
    input  logic                   wb_resetn,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [WB_ADDR_W-1:0]   wb_adr_i,
    input  logic [WB_DATA_W/8-1:0] wb_sel_i,
    input  logic [WB_DATA_W-1:0]   wb_dat_i,
    input  logic [2:0]             wb_cti_i,
    input  logic [1:0]             wb_bte_i,
    output logic [WB_DATA_W-1:0]   wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o
);

    localparam int unsigned LSB = wb_lsb(WB_DATA_W);
    localparam int unsigned WAW = WB_ADDR_W - LSB;
    localparam int unsigned NB  = WB_DATA_W / 8;

    wb_state_e            r_state;
    logic [WAW-1:0]       r_adr;
    logic [WB_DATA_W-1:0] r_dat;
    logic                 r_ack;
    logic                 r_err;
    logic [WB_DATA_W-1:0] r_mem [2**MEM_AW];

    logic [WAW-1:0]       w_req_word;
    logic [WAW-1:0]       w_next_word;
    logic [WAW-1:0]       w_load_word;
    logic [MEM_AW-1:0]    w_load_idx;
    logic                 w_load_oor;
    logic                 w_beat_done;
    logic                 w_wr_en;
    logic                 w_burst_start;
    logic                 w_burst_more;

    assign w_req_word  = wb_adr_i[WB_ADDR_W-1:LSB];
    assign w_beat_done = wb_cyc_i & wb_stb_i & (r_ack | r_err);
    assign w_wr_en     = w_beat_done & wb_we_i & r_ack;

`ifdef OVI_WB_BURST_EN
    logic w_unused;
    assign w_unused      = ^wb_adr_i;
    assign w_burst_start = (wb_cti_i == CTI_CONST) || (wb_cti_i == CTI_INCR);
    assign w_burst_more  = w_burst_start;

    ovi_wb_burst_addr #(
        .AW(WAW)
    ) u_burst_addr (
        .i_cur  (r_adr),
        .i_cti  (cti_e'(wb_cti_i)),
        .i_bte  (bte_e'(wb_bte_i)),
        .o_next (w_next_word)
    );
`else
    logic w_unused;
    assign w_unused      = ^{wb_adr_i, wb_cti_i, wb_bte_i};
    assign w_burst_start = 1'b0;
    assign w_burst_more  = 1'b0;
    assign w_next_word   = r_adr;
`endif

    // Address to register a response for: bus address when idle, else burst index
    always_comb begin
        w_load_word = r_adr;
        if (r_state == S_IDLE) begin
            w_load_word = w_req_word;
        end else if (w_beat_done) begin
            w_load_word = w_next_word;
        end
    end

    assign w_load_idx = w_load_word[MEM_AW-1:0];
    assign w_load_oor = |w_load_word[WAW-1:MEM_AW];

    // Byte-lane writes commit only on a completed, in-range write beat
    always_ff @(posedge wb_clk) begin
        if (w_wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wb_sel_i[b]) begin
                    r_mem[r_adr[MEM_AW-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Bus FSM: registers ack/err/data for the address about to be presented
    always_ff @(posedge wb_clk or negedge wb_resetn) begin
        if (!wb_resetn) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else if (!wb_cyc_i) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (wb_stb_i) begin
                        r_adr   <= w_load_word;
                        r_ack   <= !w_load_oor;
                        r_err   <= w_load_oor;
                        r_dat   <= w_load_oor ? '0 : r_mem[w_load_idx];
                        r_state <= w_burst_start ? S_BURST : S_CLASSIC;
                    end
                end
                S_CLASSIC: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_BURST: begin
                    if (!wb_stb_i) begin
                        // master wait state: drop the strobe response, keep r_adr
                        r_ack <= 1'b0;
                        r_err <= 1'b0;
                    end else if (w_beat_done && !w_burst_more) begin
                        // any completed beat not tagged CONST/INCR closes the burst
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // next beat, or re-present the held address after a wait state
                        r_adr <= w_load_word;
                        r_ack <= !w_load_oor;
                        r_err <= w_load_oor;
                        r_dat <= w_load_oor ? '0 : r_mem[w_load_idx];
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_ovi_wb_ram_slave.sv
// tb_ovi_wb_ram_slave: directed Wishbone accesses with a response scoreboard.
// Burst sequences are exercised when OVI_WB_BURST_EN is defined.
module tb_ovi_wb_ram_slave;
    import ovi_wb_pkg::*;

    typedef struct {
        int unsigned t;
        logic        err;
        logic [31:0] dat;
        logic        ck;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_i;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack, err, rty;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc_cnt = 0;
    logic        prev_stb = 1'b0;
    exp_t        sbq[$];
    logic [31:0] wdat [16];
    logic [31:0] bexp [16];

    ovi_wb_ram_slave #(
        .WB_ADDR_W(32),
        .WB_DATA_W(32),
        .MEM_AW(10)
    ) dut (
        .wb_clk    (clk),
        .wb_resetn (resetn),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (dat_i),
        .wb_cti_i  (cti),
        .wb_bte_i  (bte),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .wb_rty_o  (rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int unsigned t, input logic e, input logic [31:0] d, input logic ck);
        exp_t x;
        x.t = t; x.err = e; x.dat = d; x.ck = ck;
        sbq.push_back(x);
    endtask

    // Monitor: every presented, strobed response pops one expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stb = 1'b0;
            end else begin
                if (ack | err) begin
                    chk("ack_err_excl", 64'(ack & err), 64'd0);
                    if (!cyc) begin
                        chk("ack_no_cyc", 64'({ack, err}), 64'd0);
                    end else if (stb) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_resp", 64'({ack, err}), 64'd0);
                        end else begin
                            exp_t e;
                            e = sbq.pop_front();
                            chk("resp_cycle", 64'(cyc_cnt), 64'(e.t));
                            chk("resp_kind", 64'({ack, err}), e.err ? 64'd1 : 64'd2);
                            if (e.ck) chk("resp_data", 64'(dat_o), 64'(e.dat));
                        end
                    end else if (!prev_stb) begin
                        chk("ack_in_gap", 64'({ack, err}), 64'd0);
                    end
                end
                prev_stb = cyc & stb;
            end
        end
    end

    task automatic wait_hs(input string nm);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack | err) && n < 8);
        if (!(ack | err)) begin
            total++;
            bad++;
            $display("FAIL %s: no ack/err within %0d cycles, response required", nm, n);
        end
    endtask

    task automatic classic(input logic cwe, input logic [2:0] ccti, input logic [31:0] cadr,
                           input logic [3:0] csel, input logic [31:0] cd,
                           input logic eerr, input logic [31:0] edat);
        @(posedge clk); #2;
        cyc = 1'b1; stb = 1'b1; we = cwe; adr = cadr; sel = csel; dat_i = cd;
        cti = ccti; bte = BTE_WRAP4;
        push(cyc_cnt + 1, eerr, edat, !cwe);
        wait_hs("classic");
        @(posedge clk); #2;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
    endtask

    // Asserted while a response is on the bus; outputs must clear at once
    task automatic reset_mid();
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_ackerr", 64'({ack, err}), 64'd0);
        chk("rst_mid_dat", 64'(dat_o), 64'd0);
        chk("rst_mid_rty", 64'(rty), 64'd0);
        @(posedge clk); #2;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        @(posedge clk); #2;
        resetn = 1'b1;
    endtask

`ifdef OVI_WB_BURST_EN
    task automatic burst(input logic bwe, input int w0, input logic [1:0] bbte, input int nb,
                         input int gap_at, input int gap_len, input int rst_at);
        int unsigned t;
        @(posedge clk); #2;
        cyc = 1'b1; stb = 1'b1; we = bwe; adr = 32'(w0) << 2; sel = 4'hF; bte = bbte;
        cti = (nb == 1) ? CTI_EOB : CTI_INCR;
        dat_i = wdat[0];
        t = cyc_cnt + 1;
        for (int b = 0; b < nb; b++) begin
            push(t, 1'b0, bexp[b], !bwe);
            wait_hs("burst_beat");
            if (b == rst_at) begin
                reset_mid();
                return;
            end
            @(posedge clk); #2;
            t = cyc_cnt;
            if (b == nb - 1) begin
                cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
            end else begin
                cti = (b + 1 == nb - 1) ? CTI_EOB : CTI_INCR;
                dat_i = wdat[b + 1];
                if (b == gap_at) begin
                    stb = 1'b0;
                    repeat (gap_len) @(posedge clk);
                    #2;
                    stb = 1'b1;
                    t = cyc_cnt + 1;
                end
            end
        end
    endtask
`endif

    initial begin
        resetn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = '0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ackerr", 64'({ack, err}), 64'd0);
        chk("reset_rty", 64'(rty), 64'd0);
        chk("reset_dat", 64'(dat_o), 64'd0);
        resetn = 1'b1;

        classic(1'b1, CTI_CLASSIC, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, '0);
        classic(1'b0, CTI_CLASSIC, 32'h10, 4'hF, '0, 1'b0, 32'hDEADBEEF);
        classic(1'b1, CTI_CLASSIC, 32'h20, 4'hF, 32'h11223344, 1'b0, '0);
        classic(1'b1, CTI_CLASSIC, 32'h20, 4'b0010, 32'h0000AA00, 1'b0, '0);
        classic(1'b0, CTI_CLASSIC, 32'h20, 4'hF, '0, 1'b0, 32'h1122AA44);
        classic(1'b1, CTI_CLASSIC, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, '0);
        classic(1'b0, CTI_CLASSIC, 32'h1000, 4'hF, '0, 1'b1, 32'h0);
        classic(1'b1, CTI_CLASSIC, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1, '0);
        classic(1'b0, CTI_CLASSIC, 32'h0, 4'hF, '0, 1'b0, 32'h0BADF00D);

`ifdef OVI_WB_BURST_EN
        for (int i = 0; i < 4; i++) wdat[i] = 32'hC0DE0004 + 32'(i);
        burst(1'b1, 4, BTE_LINEAR, 4, -1, 0, -1);
        bexp[0] = 32'hC0DE0006; bexp[1] = 32'hC0DE0007;
        bexp[2] = 32'hC0DE0004; bexp[3] = 32'hC0DE0005;
        burst(1'b0, 6, BTE_WRAP4, 4, -1, 0, -1);

        for (int i = 0; i < 5; i++) wdat[i] = 32'h5EED0008 + 32'(i);
        burst(1'b1, 8, BTE_LINEAR, 5, 1, 2, -1);
        for (int i = 0; i < 5; i++) bexp[i] = 32'h5EED0008 + 32'(i);
        burst(1'b0, 8, BTE_LINEAR, 5, 2, 2, -1);

        burst(1'b0, 8, BTE_LINEAR, 5, -1, 0, 2);
`else
        classic(1'b0, CTI_INCR, 32'h10, 4'hF, '0, 1'b0, 32'hDEADBEEF);
        @(posedge clk); #2;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 4'hF; cti = CTI_INCR;
        push(cyc_cnt + 1, 1'b0, 32'h1122AA44, 1'b1);
        wait_hs("rst_access");
        reset_mid();
`endif
        classic(1'b0, CTI_CLASSIC, 32'h0, 4'hF, '0, 1'b0, 32'h0BADF00D);

        repeat (4) @(posedge clk);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
